// File: rtl/ryuki_mem_pkg.sv
// Shared constants, response record and byte-lane merge helper for the ryuki data memory.
package ryuki_mem_pkg;

  localparam int unsigned DMEM_DATA_WIDTH  = 32;
  localparam int unsigned BYTES_PER_WORD   = DMEM_DATA_WIDTH / 8;
  localparam int unsigned BYTE_OFFSET_BITS = $clog2(BYTES_PER_WORD);

  typedef struct packed {
    logic                       valid;
    logic                       err;
    logic [DMEM_DATA_WIDTH-1:0] rdata;
  } mem_rsp_t;

  // Replace the bytes of old_word selected by be with the matching bytes of new_word.
  function automatic logic [DMEM_DATA_WIDTH-1:0] be_merge(
    input logic [DMEM_DATA_WIDTH-1:0] old_word,
    input logic [DMEM_DATA_WIDTH-1:0] new_word,
    input logic [BYTES_PER_WORD-1:0]  be
  );
    logic [DMEM_DATA_WIDTH-1:0] res;
    res = old_word;
    for (int k = 0; k < int'(BYTES_PER_WORD); k++) begin
      if (be[k]) res[8*k +: 8] = new_word[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ryuki_data_memory.sv
// Single-port word-organised data RAM for the LSU: same-cycle grant, one-cycle response.
// Define DMEM_ADDR_CHECK_EN to flag out-of-range accesses; otherwise the index wraps.
module ryuki_data_memory
  import ryuki_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int unsigned NUM_WORDS  = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    gnt_o,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o
);

  localparam int unsigned IDX_FULL_W = ADDR_WIDTH - BYTE_OFFSET_BITS;
  localparam int unsigned IDX_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  // The response record and merge helper are sized by the package word width.
  if (DATA_WIDTH != DMEM_DATA_WIDTH) begin : g_width_check
    $error("ryuki_data_memory: DATA_WIDTH must equal ryuki_mem_pkg::DMEM_DATA_WIDTH");
  end

  logic [DATA_WIDTH-1:0] r_mem [NUM_WORDS];
  mem_rsp_t              r_rsp;

  logic [IDX_FULL_W-1:0] w_idx_full;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_err;
  logic                  w_wr_en;
  logic                  w_unused_addr_lsb;

  assign w_idx_full        = addr_i[ADDR_WIDTH-1:BYTE_OFFSET_BITS];
  assign w_unused_addr_lsb = ^addr_i[BYTE_OFFSET_BITS-1:0];
  // Modulo keeps every access inside the array; with the check enabled it is only
  // consulted for in-range indices, where it is the identity.
  assign w_idx = IDX_W'(w_idx_full % IDX_FULL_W'(NUM_WORDS));

`ifdef DMEM_ADDR_CHECK_EN
  logic w_in_range;
  assign w_in_range = (w_idx_full < IDX_FULL_W'(NUM_WORDS));
  assign w_err      = ~w_in_range;
`else
  assign w_err = 1'b0;
`endif

  assign w_wr_en = req_i & we_i & ~w_err;

  // Storage is deliberately not reset so contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[w_idx] <= be_merge(r_mem[w_idx], wdata_i, be_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp <= '0;
    end else begin
      r_rsp.valid <= req_i;
      if (req_i) begin
        r_rsp.err   <= w_err;
        r_rsp.rdata <= (we_i || w_err) ? '0 : r_mem[w_idx];
      end else begin
        r_rsp.err <= 1'b0;
      end
    end
  end

  assign gnt_o    = req_i;
  assign rvalid_o = r_rsp.valid;
  assign err_o    = r_rsp.err;
  assign rdata_o  = r_rsp.rdata;

endmodule

// File: tb/tb_ryuki_data_memory.sv
// Self-checking bench for ryuki_data_memory: vector table, corner sequences and random traffic
// against a word-array reference model.
module tb_ryuki_data_memory;

  localparam int unsigned NW = 1024;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mdl_mem [NW];
  logic [31:0] mdl_last = 32'h0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [12];

  ryuki_data_memory #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .NUM_WORDS (NW)
  ) u_dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req),
    .addr_i  (addr),
    .we_i    (we),
    .be_i    (be),
    .wdata_i (wdata),
    .gnt_o   (gnt),
    .rvalid_o(rvalid),
    .rdata_o (rdata),
    .err_o   (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Reference: memory as a plain word array indexed by addr/4.
  task automatic model(input logic r, input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, output logic ev, output logic ee,
                       output logic [31:0] ed);
    int unsigned idx;
    if (!r) begin
      ev = 1'b0;
      ee = 1'b0;
      ed = mdl_last;
      return;
    end
    ev  = 1'b1;
    ee  = 1'b0;
    idx = a / 4;
`ifdef DMEM_ADDR_CHECK_EN
    if (idx >= NW) begin
      ee       = 1'b1;
      ed       = 32'h0;
      mdl_last = ed;
      return;
    end
`endif
    idx = idx % NW;
    if (w) begin
      for (int k = 0; k < 4; k++) begin
        if (b[k]) mdl_mem[idx][8*k +: 8] = d[8*k +: 8];
      end
      ed = 32'h0;
    end else begin
      ed = mdl_mem[idx];
    end
    mdl_last = ed;
  endtask

  // Called at a negedge: drives one cycle of inputs, checks grant, then checks the response
  // at the next negedge. ovr replaces the model's error/data expectation with fixed values.
  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, input logic ovr, input logic ovr_err,
                      input logic [31:0] ovr_rdata, input string nm);
    logic        ev;
    logic        ee;
    logic [31:0] ed;
    req   = r;
    we    = w;
    addr  = a;
    be    = b;
    wdata = d;
    #1;
    chk({nm, ".gnt"}, {31'b0, gnt}, {31'b0, r});
    model(r, w, a, b, d, ev, ee, ed);
    if (ovr) begin
      ee = ovr_err;
      ed = ovr_rdata;
    end
    @(negedge clk);
    chk({nm, ".rvalid"}, {31'b0, rvalid}, {31'b0, ev});
    chk({nm, ".err"}, {31'b0, err}, {31'b0, ee});
    chk({nm, ".rdata"}, rdata, ed);
  endtask

  initial begin
    logic        r_r;
    logic        r_w;
    logic [31:0] r_a;
    logic [3:0]  r_b;
    logic [31:0] r_d;

    tbl[0]  = '{1'b1, 32'h40, 4'hF, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b0, 32'h40, 4'h0, 32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1'b1, 32'h40, 4'h5, 32'h11223344, 32'h0};
    tbl[3]  = '{1'b0, 32'h40, 4'hF, 32'h0,        32'hDE22BE44};
    tbl[4]  = '{1'b0, 32'h43, 4'h0, 32'h0,        32'hDE22BE44};
    tbl[5]  = '{1'b1, 32'h84, 4'hF, 32'h0BADF00D, 32'h0};
    tbl[6]  = '{1'b1, 32'h80, 4'hF, 32'hA5A5A5A5, 32'h0};
    tbl[7]  = '{1'b0, 32'h80, 4'h0, 32'h0,        32'hA5A5A5A5};
    tbl[8]  = '{1'b0, 32'h84, 4'h0, 32'h0,        32'h0BADF00D};
    tbl[9]  = '{1'b0, 32'h80, 4'h0, 32'h0,        32'hA5A5A5A5};
    tbl[10] = '{1'b1, 32'h40, 4'h0, 32'hFFFFFFFF, 32'h0};
    tbl[11] = '{1'b0, 32'h40, 4'h0, 32'h0,        32'hDE22BE44};

    // Reset held with a request asserted: grant passes through, response stays quiet.
    rst_n = 1'b0;
    req   = 1'b1;
    we    = 1'b0;
    addr  = 32'h0;
    be    = 4'h0;
    wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst.gnt", {31'b0, gnt}, 32'h1);
    chk("rst.rvalid", {31'b0, rvalid}, 32'h0);
    chk("rst.err", {31'b0, err}, 32'h0);
    chk("rst.rdata", rdata, 32'h0);
    rst_n = 1'b1;
    req   = 1'b0;

    step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, "idle");
    step(1'b1, 1'b1, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, "first");

    // Give every word a known value.
    for (int i = 0; i < int'(NW); i++) begin
      step(1'b1, 1'b1, 32'(i * 4), 4'hF, $urandom, 1'b0, 1'b0, 32'h0, "preload");
    end

    // Vector table, back to back with no idle cycles.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wdata, 1'b1, 1'b0, tbl[i].exp_rdata,
           $sformatf("tbl%0d", i));
    end
    step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'hDE22BE44, "hold");

    // Asynchronous reset with a read response pending; contents must survive.
    req  = 1'b1;
    we   = 1'b0;
    addr = 32'h40;
    @(posedge clk);
    #2;
    chk("arst.pending", {31'b0, rvalid}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst.rvalid", {31'b0, rvalid}, 32'h0);
    chk("arst.rdata", rdata, 32'h0);
    mdl_last = 32'h0;
    req      = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b1, 1'b0, 32'hDE22BE44, "arst.reread");

    // Out-of-range access at 0x1000 (word 1024).
    step(1'b1, 1'b1, 32'h0, 4'hF, 32'h12345678, 1'b0, 1'b0, 32'h0, "oor.w0");
`ifdef DMEM_ADDR_CHECK_EN
    step(1'b1, 1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, 1'b1, 1'b1, 32'h0, "oor.wr");
    step(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h12345678, "oor.rd0");
    step(1'b1, 1'b0, 32'h1000, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0, "oor.rd");
`else
    step(1'b1, 1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0, "oor.wr");
    step(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'hCAFEF00D, "oor.rd0");
    step(1'b1, 1'b0, 32'h1000, 4'h0, 32'h0, 1'b1, 1'b0, 32'hCAFEF00D, "oor.rd");
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r_r = ($urandom_range(0, 3) != 0);
      r_w = $urandom_range(0, 1) == 1;
      r_a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 32'h0FFF));
      r_b = 4'($urandom_range(0, 15));
      r_d = $urandom;
      step(r_r, r_w, r_a, r_b, r_d, 1'b0, 1'b0, 32'h0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
